pulse_period_meter: RTL and testbench

Measures the interval, in clock cycles, between consecutive rising edges of a pulse input: a tick from the team's divider, or an external strobe. It is the receiving end of the tick-generation path. It synchronises the input, detects rising edges, counts cycles between them, reports each completed period with a one-cycle valid strobe, and flags a timeout when no edge arrives within a configured window.

---
 rtl/pulse_sync_edge.sv | 31 +++
 rtl/pulse_period_meter.sv | 89 ++++++++
 tb/tb_pulse_period_meter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pulse_sync_edge.sv
// Synchronises an asynchronous strobe into the clock domain and flags its rising edges.
// Reusable by any block that consumes ticks or external strobes.
module pulse_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic edge_det
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev   <= s;
    end
  end

  // Driven only from flops, so downstream logic sees a clean one-cycle pulse.
  assign edge_det = s & ~prev;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures cycles between consecutive rising edges of pulse_in and flags a missing edge.
// period_valid is a one-cycle strobe with no back-pressure; period holds until the next strobe.
module pulse_period_meter #(
  parameter int FREQ        = 50_000_000,
  parameter int MAX_PERIOD  = 1,
  parameter int SYNC_STAGES = 2,
  localparam int MAX_COUNT  = FREQ * MAX_PERIOD,
  localparam int COUNT_LEN  = $clog2(MAX_COUNT + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pulse_in,
  output logic [COUNT_LEN-1:0] period,
  output logic                 period_valid,
  output logic                 timeout,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  localparam logic [COUNT_LEN-1:0] MAX_CNT = COUNT_LEN'(MAX_COUNT);
  localparam logic [COUNT_LEN-1:0] ONE     = COUNT_LEN'(1);

  state_t               state_q;
  logic [COUNT_LEN-1:0] cnt;
  logic                 edge_det;

  pulse_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clock   (clock),
    .reset   (reset),
    .async_in(pulse_in),
    .edge_det(edge_det)
  );

  assign state = state_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (edge_det) begin
            state_q <= MEASURE;
            cnt     <= ONE;
          end
        end
        MEASURE: begin
          // An edge on the last allowed cycle still counts as a valid period.
          if (edge_det) begin
            period       <= cnt;
            period_valid <= 1'b1;
            cnt          <= ONE;
          end else if (cnt == MAX_CNT) begin
            state_q <= TIMEOUT;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        TIMEOUT: begin
          // The interval that ended here overran the window, so it is not reported.
          if (edge_det) begin
            state_q <= MEASURE;
            cnt     <= ONE;
            timeout <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt     <= '0;
          timeout <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed, table-driven bench for pulse_period_meter (FREQ=20, MAX_PERIOD=1, SYNC_STAGES=2).
module tb_pulse_period_meter;

  localparam int N_STEPS = 240;

  logic       clock;
  logic       reset;
  logic       pulse_in;
  logic [4:0] period;
  logic       period_valid;
  logic       timeout;
  logic [1:0] state;

  int n_cmp;
  int n_bad;

  pulse_period_meter #(
    .FREQ       (20),
    .MAX_PERIOD (1),
    .SYNC_STAGES(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pulse_in    (pulse_in),
    .period      (period),
    .period_valid(period_valid),
    .timeout     (timeout),
    .state       (state)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       pulse;
    logic       rst;
    logic       valid;
    logic [4:0] period;
    logic       tmo;
  } vec_t;

  vec_t vec[N_STEPS];
  int   tmo_evt[N_STEPS];

  task automatic check(input string name, input int step, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at step %0d: got %0d, want %0d", name, step, got, exp);
    end
  endtask

  // Driver helpers: step c means inputs held before clock edge c, outputs observed just after it.
  task automatic pulse_at(input int c);
    vec[c].pulse = 1'b1;
  endtask

  task automatic strobe_at(input int c, input logic [4:0] p);
    vec[c].valid  = 1'b1;
    vec[c].period = p;
  endtask

  task automatic fill_table();
    for (int c = 0; c < N_STEPS; c++) begin
      vec[c] = '{pulse: 1'b0, rst: 1'b0, valid: 1'b0, period: 5'd0, tmo: 1'b0};
      tmo_evt[c] = 0;
    end
    for (int c = 0; c < 3; c++) vec[c].rst = 1'b1;
    // Periodic: 5 pulses every 10 cycles, strobes 2 cycles after each sampled pulse
    for (int k = 0; k < 5; k++) pulse_at(10 + 10 * k);
    for (int k = 1; k < 5; k++) strobe_at(12 + 10 * k, 5'd10);
    // Silence after pulse 50: edge seen at 51, timeout 21 cycles later
    tmo_evt[72] = 1;
    pulse_at(80);
    tmo_evt[82] = 2;
    pulse_at(87);
    strobe_at(89, 5'd7);
    // Gap of exactly MAX_COUNT: edge wins, no timeout
    pulse_at(107);
    strobe_at(109, 5'd20);
    // Gap of 21: timeout for one cycle, no strobe
    pulse_at(128);
    tmo_evt[129] = 1;
    tmo_evt[130] = 2;
    // Minimum period pattern 1,0,1,0
    for (int k = 0; k < 4; k++) pulse_at(140 + 2 * k);
    strobe_at(142, 5'd12);
    strobe_at(144, 5'd2);
    strobe_at(146, 5'd2);
    strobe_at(148, 5'd2);
    // Held high for 30 cycles: one edge, then timeout
    for (int c = 160; c < 190; c++) pulse_at(c);
    strobe_at(162, 5'd14);
    tmo_evt[182] = 1;
    // Reset in the middle of a measurement
    pulse_at(200);
    tmo_evt[202] = 2;
    pulse_at(210);
    strobe_at(212, 5'd10);
    vec[215].rst = 1'b1;
    pulse_at(220);
    pulse_at(226);
    strobe_at(228, 5'd6);
  endtask

  // Turn sparse events into full per-step expectations (period and timeout are levels).
  task automatic propagate_levels();
    logic [4:0] per;
    logic       tmo;
    per = 5'd0;
    tmo = 1'b0;
    for (int c = 0; c < N_STEPS; c++) begin
      if (vec[c].rst) begin
        per = 5'd0;
        tmo = 1'b0;
      end else begin
        if (vec[c].valid) per = vec[c].period;
        if (tmo_evt[c] == 1) tmo = 1'b1;
        if (tmo_evt[c] == 2) tmo = 1'b0;
      end
      vec[c].period = per;
      vec[c].tmo    = tmo;
    end
  endtask

  initial begin
    int         got_step;
    logic [4:0] got_period;

    n_cmp    = 0;
    n_bad    = 0;
    reset    = 1'b1;
    pulse_in = 1'b0;

    fill_table();
    propagate_levels();

    for (int i = 0; i < N_STEPS; i++) begin
      pulse_in = vec[i].pulse;
      reset    = vec[i].rst;
      @(posedge clock);
      #1;
      check("period_valid", i, 32'(period_valid), 32'(vec[i].valid));
      check("period", i, 32'(period), 32'(vec[i].period));
      check("timeout", i, 32'(timeout), 32'(vec[i].tmo));
      if (vec[i].rst) check("state_after_reset", i, 32'(state), 32'd0);
    end

    // pulse_in already high when reset releases counts as the first edge
    reset    = 1'b1;
    pulse_in = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_hi_state", 0, 32'(state), 32'd0);
    check("reset_hi_timeout", 0, 32'(timeout), 32'd0);
    reset      = 1'b0;
    got_step   = -1;
    got_period = 5'd0;
    for (int j = 0; j < 20; j++) begin
      pulse_in = (j == 0 || j == 5);
      @(posedge clock);
      #1;
      if (period_valid && got_step < 0) begin
        got_step   = j;
        got_period = period;
      end
    end
    check("held_at_release_strobe_step", 0, 32'(got_step), 32'd7);
    check("held_at_release_period", 0, 32'(got_period), 32'd5);
    check("held_at_release_state", 0, 32'(state), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
